// File: rtl/instr_fetch_decode_pkg.sv
// Shared definitions for the instruction fetch/decode block: FSM encoding,
// instruction field positions and the default halt opcode.
package instr_fetch_decode_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } fetch_state_e;

   localparam logic [5:0] HALT_OP_DEFAULT = 6'h3F;

   localparam int OPC_LSB   = 26;
   localparam int OPC_W     = 6;
   localparam int RS_LSB    = 21;
   localparam int RT_LSB    = 16;
   localparam int RD_LSB    = 11;
   localparam int REG_W     = 5;
   localparam int IMM_LSB   = 0;
   localparam int IMM_W     = 16;
   localparam int FUNCT_LSB = 0;
   localparam int FUNCT_W   = 6;

   function automatic logic [5:0] opcode_of(input logic [31:0] word);
      return word[OPC_LSB +: OPC_W];
   endfunction

endpackage

// File: rtl/instr_fetch_decode_skid_fifo.sv
// Two-entry registered FIFO sitting between the instruction memory and the
// decode outputs; the head entry drives the outputs directly.
module instr_skid_fifo #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic [1:0]   count
);

   logic [W-1:0] ent0_q, ent0_d;
   logic [W-1:0] ent1_q, ent1_d;
   logic [1:0]   cnt_q, cnt_d, cnt_mid;

   always_comb begin
      ent0_d  = ent0_q;
      ent1_d  = ent1_q;
      cnt_d   = cnt_q;
      cnt_mid = cnt_q;
      if (flush) begin
         ent0_d = '0;
         ent1_d = '0;
         cnt_d  = 2'd0;
      end else begin
         if (pop && (cnt_q != 2'd0)) begin
            ent0_d  = ent1_q;
            cnt_mid = cnt_q - 2'd1;
         end
         // a push lands behind whatever survives the pop
         if (push && (cnt_mid != 2'd2)) begin
            if (cnt_mid == 2'd0) ent0_d = push_data;
            else                 ent1_d = push_data;
            cnt_d = cnt_mid + 2'd1;
         end else begin
            cnt_d = cnt_mid;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ent0_q <= '0;
         ent1_q <= '0;
         cnt_q  <= 2'd0;
      end else begin
         ent0_q <= ent0_d;
         ent1_q <= ent1_d;
         cnt_q  <= cnt_d;
      end
   end

   assign out_valid = (cnt_q != 2'd0);
   assign out_data  = ent0_q;
   assign count     = cnt_q;

endmodule

// File: rtl/instr_fetch_decode.sv
// Instruction memory with sequential fetch, redirect and halt handling,
// feeding decoded fields through a two-entry output FIFO.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | after reset; waits for run, redirects ignored
//   ST_RUN  | fetching from pc_q, delivering decoded words (busy=1)
//   ST_DONE | halt word consumed; run restarts at RESET_PC, redirect at redir_pc
module instr_fetch_decode
   import instr_fetch_decode_pkg::*;
#(
   parameter int         DEPTH    = 256,
   parameter int         RESET_PC = 0,
   parameter logic [5:0] HALT_OP  = HALT_OP_DEFAULT,
   localparam int        AW       = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [31:0]   load_data,
   input  logic          run,
   input  logic          redir_valid,
   input  logic [AW-1:0] redir_pc,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] out_pc,
   output logic [5:0]    opcode,
   output logic [4:0]    rs,
   output logic [4:0]    rt,
   output logic [4:0]    rd,
   output logic [15:0]   imm,
   output logic [5:0]    funct,
   output logic          busy
);

   fetch_state_e  state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [AW-1:0] rd_pc_q, rd_pc_d;
   logic          inflight_q, inflight_d;
   logic          halt_seen_q, halt_seen_d;
   logic          busy_q, busy_d;
   logic [31:0]   rd_data_q;
   logic [31:0]   mem_q [DEPTH];

   logic          issue, fifo_push, fifo_flush, xfer, rd_is_halt, redir_take;
   logic [1:0]    fifo_count;
   logic [2:0]    occupancy;
   logic [AW+31:0] head;
   logic [31:0]   head_instr;

   assign xfer       = out_valid && out_ready;
   assign rd_is_halt = (opcode_of(rd_data_q) == HALT_OP);
   assign redir_take = redir_valid && (state_q != ST_IDLE);
   // slots already committed once this cycle's transfer leaves the FIFO
   assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, xfer};

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      halt_seen_d = halt_seen_q;
      busy_d      = busy_q;
      inflight_d  = 1'b0;
      issue       = 1'b0;
      fifo_push   = 1'b0;
      fifo_flush  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (run) begin
               state_d     = ST_RUN;
               pc_d        = AW'(RESET_PC);
               halt_seen_d = 1'b0;
               busy_d      = 1'b1;
            end
         end
         ST_RUN: begin
            if (redir_take) begin
               fifo_flush  = 1'b1;
               pc_d        = redir_pc;
               halt_seen_d = 1'b0;
            end else begin
               fifo_push = inflight_q && !halt_seen_q;
               if (fifo_push && rd_is_halt) halt_seen_d = 1'b1;
               issue = !halt_seen_q && !(inflight_q && rd_is_halt) && (occupancy < 3'd2);
               inflight_d = issue;
               if (issue) pc_d = pc_q + AW'(1);
               if (xfer && (opcode == HALT_OP)) begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
               end
            end
         end
         ST_DONE: begin
            if (redir_take || run) begin
               state_d     = ST_RUN;
               pc_d        = redir_take ? redir_pc : AW'(RESET_PC);
               halt_seen_d = 1'b0;
               busy_d      = 1'b1;
               fifo_flush  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
      rd_pc_d = issue ? pc_q : rd_pc_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pc_q        <= AW'(RESET_PC);
         rd_pc_q     <= '0;
         inflight_q  <= 1'b0;
         halt_seen_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         rd_pc_q     <= rd_pc_d;
         inflight_q  <= inflight_d;
         halt_seen_q <= halt_seen_d;
         busy_q      <= busy_d;
      end
   end

   // memory is never cleared; the read register returns pre-write data on a collision
   always_ff @(posedge clk) begin
      if (load_en && !rst) mem_q[load_addr] <= load_data;
      if (issue) rd_data_q <= mem_q[pc_q];
   end

   instr_skid_fifo #(
      .W (AW + 32)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (fifo_flush),
      .push      (fifo_push),
      .push_data ({rd_pc_q, rd_data_q}),
      .pop       (xfer),
      .out_valid (out_valid),
      .out_data  (head),
      .count     (fifo_count)
   );

   assign head_instr = head[31:0];
   assign out_pc     = head[AW+31:32];
   assign opcode     = head_instr[OPC_LSB +: OPC_W];
   assign rs         = head_instr[RS_LSB +: REG_W];
   assign rt         = head_instr[RT_LSB +: REG_W];
   assign rd         = head_instr[RD_LSB +: REG_W];
   assign imm        = head_instr[IMM_LSB +: IMM_W];
   assign funct      = head_instr[FUNCT_LSB +: FUNCT_W];
   assign busy       = busy_q;

endmodule
